neuron_hidden_delta: RTL and testbench

Backward-pass counterpart of the hidden-layer neuron. It computes the hidden error term delta_h = f'(a) * sum_k(w_k * delta_k), with f'(a) = a*(1-a) for the sigmoid activation.
- a is the forward activation the hidden neuron produced.
- (w_k, delta_k) pairs arrive from the N_OUT downstream neurons over a valid/ready stream.
- All data is signed 20-bit Q6.14 fixed point (1.0 = 20'sh04000), the same format as the forward-path neuron signals.
- Result goes to the weight-update logic through a valid/ready output.

---
 rtl/neuron_hidden_delta.sv | 136 +++++++++++++
 tb/tb_neuron_hidden_delta.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_hidden_delta.sv
// Hidden-layer backward pass: delta_h = a*(1-a) * sum_k(w_k*delta_k) in signed Q6.14.
// Pairs stream in over valid/ready; the result is held on a valid/ready output until taken.
module neuron_hidden_delta #(
  parameter int N_OUT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic signed [19:0] act_in_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic signed [19:0] w_in_i,
  input  logic signed [19:0] d_in_i,
  output logic               busy_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic signed [19:0] delta_out_o
);

  localparam int FRAC  = 14;
  localparam int W     = 20;
  localparam int ACC_W = 2 * W + $clog2(N_OUT) + 1;
  localparam int CNT_W = $clog2(N_OUT + 1);

  localparam logic signed [W-1:0] MAX20 = 20'sh7FFFF;
  localparam logic signed [W-1:0] MIN20 = 20'sh80000;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    DERIV,
    MUL,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic signed [ACC_W-1:0] acc_q;
  logic        [CNT_W-1:0] cnt_q;
  logic signed [W-1:0]     act_q;
  logic signed [W-1:0]     s_q;
  logic signed [W-1:0]     d_q;
  logic signed [W-1:0]     delta_q;

  logic signed [2*W-1:0]   pair_prod;
  logic signed [ACC_W-1:0] acc_sh;
  logic signed [W:0]       one_minus_a;
  logic signed [2*W:0]     deriv_prod;
  logic signed [2*W:0]     deriv_sh;
  logic signed [2*W-1:0]   mul_prod;
  logic signed [2*W-1:0]   mul_sh;
  logic                    last_beat;

  function automatic logic signed [W-1:0] sat20(input logic signed [63:0] x);
    if (x > 64'sd524287) begin
      return MAX20;
    end else if (x < -64'sd524288) begin
      return MIN20;
    end else begin
      return x[W-1:0];
    end
  endfunction

  // All shifts are arithmetic, so every rounding step is a floor.
  always_comb begin
    pair_prod   = (2*W)'(w_in_i) * (2*W)'(d_in_i);
    acc_sh      = acc_q >>> FRAC;
    one_minus_a = 21'sh04000 - {act_q[W-1], act_q};
    deriv_prod  = (2*W+1)'(act_q) * (2*W+1)'(one_minus_a);
    deriv_sh    = deriv_prod >>> FRAC;
    mul_prod    = (2*W)'(s_q) * (2*W)'(d_q);
    mul_sh      = mul_prod >>> FRAC;
    last_beat   = in_valid_i && (cnt_q == CNT_W'(N_OUT - 1));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = ACCUM;
      ACCUM:   if (last_beat) state_d = DERIV;
      DERIV:   state_d = MUL;
      MUL:     state_d = DONE;
      DONE:    if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      act_q   <= '0;
      s_q     <= '0;
      d_q     <= '0;
      delta_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            act_q <= act_in_i;
            acc_q <= '0;
            cnt_q <= '0;
          end
        end
        ACCUM: begin
          if (in_valid_i) begin
            acc_q <= acc_q + ACC_W'(pair_prod);
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DERIV: begin
          s_q <= sat20(64'(acc_sh));
          d_q <= sat20(64'(deriv_sh));
        end
        MUL: begin
          delta_q <= sat20(64'(mul_sh));
        end
        default: ;
      endcase
    end
  end

  assign in_ready_o  = (state_q == ACCUM);
  assign busy_o      = (state_q != IDLE);
  assign out_valid_o = (state_q == DONE);
  assign delta_out_o = delta_q;

endmodule

// File: tb/tb_neuron_hidden_delta.sv
// Self-checking bench for neuron_hidden_delta (N_OUT=2): directed table, random vectors
// against an arithmetic reference model, handshake/hold and mid-operation reset sequences.
module tb_neuron_hidden_delta;

   localparam int N = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [19:0] actIn;
   logic        inValid;
   logic        inReady;
   logic [19:0] wIn;
   logic [19:0] dIn;
   logic        busy;
   logic        outValid;
   logic        outReady;
   logic [19:0] deltaOut;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [19:0] act;
      logic [19:0] w0;
      logic [19:0] d0;
      logic [19:0] w1;
      logic [19:0] d1;
      logic [19:0] exp;
      bit          gaps;
   } vec_t;

   vec_t vecs[6];

   neuron_hidden_delta #(.N_OUT(N)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start),
      .act_in_i    (actIn),
      .in_valid_i  (inValid),
      .in_ready_o  (inReady),
      .w_in_i      (wIn),
      .d_in_i      (dIn),
      .busy_o      (busy),
      .out_valid_o (outValid),
      .out_ready_i (outReady),
      .delta_out_o (deltaOut)
   );

   // Free-running 10-time-unit clock.
   always #5 clk = ~clk;

   // Hard stop in case a sequence wedges despite its own cycle bounds.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference model: plain integer arithmetic with floor division and clamping.
   function automatic longint sx(input logic [19:0] v);
      return longint'($signed(v));
   endfunction

   function automatic longint floorDiv(input longint x, input longint y);
      longint q;
      q = x / y;
      if ((x % y != 0) && (x < 0)) q = q - 1;
      return q;
   endfunction

   function automatic longint clamp20(input longint x);
      if (x > 524287) return 524287;
      if (x < -524288) return -524288;
      return x;
   endfunction

   function automatic logic [19:0] refDelta(input logic [19:0] act, input logic [19:0] w0,
                                            input logic [19:0] d0, input logic [19:0] w1,
                                            input logic [19:0] d1);
      longint a, sum, s, d, r;
      a   = sx(act);
      sum = sx(w0) * sx(d0) + sx(w1) * sx(d1);
      s   = clamp20(floorDiv(sum, 16384));
      d   = clamp20(floorDiv(a * (16384 - a), 16384));
      r   = clamp20(floorDiv(s * d, 16384));
      return r[19:0];
   endfunction

   // One comparison: counts it and reports a failure line if it differs.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      total++;
      if (actual !== required) begin
         bad++;
         $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
      end
   endtask

   // Runs one computation up to out_valid and returns the delta shown there.
   task automatic applyStimulus(input string tag, input logic [19:0] act,
                                input logic [19:0] w0, input logic [19:0] d0,
                                input logic [19:0] w1, input logic [19:0] d1,
                                input bit gaps, output logic [19:0] res);
      int  idx;
      int  cyc;
      bit  v;
      bit  taken;
      @(posedge clk); #1;
      start = 1'b1;
      actIn = act;
      @(posedge clk); #1;
      start = 1'b0;
      actIn = 20'($urandom);
      checkOutput({tag, ".busyAfterStart"}, 32'(busy), 32'd1);
      checkOutput({tag, ".readyInAccum"}, 32'(inReady), 32'd1);
      idx = 0;
      cyc = 0;
      while (idx < N && cyc < 100) begin
         v       = gaps ? bit'($urandom_range(0, 1)) : 1'b1;
         inValid = v;
         if (v) begin
            wIn = (idx == 0) ? w0 : w1;
            dIn = (idx == 0) ? d0 : d1;
         end else begin
            wIn = 20'($urandom);
            dIn = 20'($urandom);
         end
         taken = v && inReady;
         @(posedge clk); #1;
         if (taken) idx++;
         cyc++;
      end
      checkOutput({tag, ".beatsTaken"}, 32'(idx), 32'(N));
      checkOutput({tag, ".noReadyAfterLast"}, 32'(inReady), 32'd0);
      checkOutput({tag, ".noValidAtE"}, 32'(outValid), 32'd0);
      inValid = 1'b1;
      wIn     = 20'h7FFFF;
      dIn     = 20'h7FFFF;
      @(posedge clk); #1;
      inValid = 1'b0;
      checkOutput({tag, ".noValidAtE1"}, 32'(outValid), 32'd0);
      @(posedge clk); #1;
      checkOutput({tag, ".validAtE2"}, 32'(outValid), 32'd1);
      res = deltaOut;
   endtask

   // Completes the output handshake, optionally with a simultaneous start pulse.
   task automatic releaseOutput(input string tag, input bit withStart);
      outReady = 1'b1;
      start    = withStart;
      @(posedge clk); #1;
      outReady = 1'b0;
      start    = 1'b0;
      checkOutput({tag, ".validCleared"}, 32'(outValid), 32'd0);
      checkOutput({tag, ".idleAfterAccept"}, 32'(busy), 32'd0);
   endtask

   initial begin
      logic [19:0] res;
      logic [19:0] held;
      logic [19:0] ra, rw0, rd0, rw1, rd1;

      vecs[0] = '{act: 20'h02000, w0: 20'h04000, d0: 20'h02000, w1: 20'h02000, d1: 20'h04000, exp: 20'h01000, gaps: 1'b0};
      vecs[1] = '{act: 20'h02000, w0: 20'h04000, d0: 20'hFC000, w1: 20'h00000, d1: 20'h04000, exp: 20'hFF000, gaps: 1'b0};
      vecs[2] = '{act: 20'h02000, w0: 20'h7FFFF, d0: 20'h7FFFF, w1: 20'h7FFFF, d1: 20'h7FFFF, exp: 20'h1FFFF, gaps: 1'b0};
      vecs[3] = '{act: 20'h04000, w0: 20'h7FFFF, d0: 20'h7FFFF, w1: 20'h80000, d1: 20'h12345, exp: 20'h00000, gaps: 1'b0};
      vecs[4] = '{act: 20'h00001, w0: 20'h04000, d0: 20'h02000, w1: 20'h02000, d1: 20'h04000, exp: 20'h00000, gaps: 1'b0};
      vecs[5] = '{act: 20'h02000, w0: 20'h04000, d0: 20'h02000, w1: 20'h02000, d1: 20'h04000, exp: 20'h01000, gaps: 1'b1};

      rst      = 1'b1;
      start    = 1'b0;
      actIn    = '0;
      inValid  = 1'b0;
      wIn      = '0;
      dIn      = '0;
      outReady = 1'b0;
      #12;
      checkOutput("reset.inReady", 32'(inReady), 32'd0);
      checkOutput("reset.busy", 32'(busy), 32'd0);
      checkOutput("reset.outValid", 32'(outValid), 32'd0);
      checkOutput("reset.deltaOut", 32'(deltaOut), 32'd0);
      rst = 1'b0;

      // Idle ignores in_valid.
      inValid = 1'b1;
      @(posedge clk); #1;
      inValid = 1'b0;
      checkOutput("idle.ignoresValid", 32'(busy), 32'd0);

      for (int i = 0; i < 6; i++) begin
         applyStimulus($sformatf("vec%0d", i), vecs[i].act, vecs[i].w0, vecs[i].d0,
                       vecs[i].w1, vecs[i].d1, vecs[i].gaps, res);
         checkOutput($sformatf("vec%0d.delta", i), 32'(res), 32'(vecs[i].exp));
         releaseOutput($sformatf("vec%0d", i), 1'b0);
      end

      for (int i = 0; i < 16; i++) begin
         ra  = (i < 8) ? 20'($signed(20'($urandom_range(0, 20'h08000))) - 20'sh02000) : 20'($urandom);
         rw0 = 20'($urandom);
         rd0 = 20'($urandom);
         rw1 = (i % 3 == 0) ? 20'($urandom) : 20'($signed(20'($urandom_range(0, 20'h10000))) - 20'sh08000);
         rd1 = (i % 3 == 0) ? 20'($urandom) : 20'($signed(20'($urandom_range(0, 20'h10000))) - 20'sh08000);
         applyStimulus($sformatf("rnd%0d", i), ra, rw0, rd0, rw1, rd1, bit'($urandom_range(0, 1)), res);
         checkOutput($sformatf("rnd%0d.delta", i), 32'(res), 32'(refDelta(ra, rw0, rd0, rw1, rd1)));
         releaseOutput($sformatf("rnd%0d", i), 1'b0);
      end

      // Output held under back-pressure; start pulses in DONE are ignored.
      applyStimulus("hold", 20'h02000, 20'h04000, 20'h02000, 20'h02000, 20'h04000, 1'b1, held);
      checkOutput("hold.delta", 32'(held), 32'h01000);
      for (int i = 0; i < 5; i++) begin
         start    = (i % 2 == 0);
         actIn    = 20'($urandom);
         outReady = 1'b0;
         @(posedge clk); #1;
         checkOutput($sformatf("hold%0d.valid", i), 32'(outValid), 32'd1);
         checkOutput($sformatf("hold%0d.delta", i), 32'(deltaOut), 32'h01000);
      end
      start = 1'b0;
      releaseOutput("hold", 1'b1);
      @(posedge clk); #1;
      checkOutput("hold.startIgnored", 32'(busy), 32'd0);
      checkOutput("hold.deltaKept", 32'(deltaOut), 32'h01000);

      // Asynchronous reset after the first of two beats.
      @(posedge clk); #1;
      start = 1'b1;
      actIn = 20'h02000;
      @(posedge clk); #1;
      start   = 1'b0;
      inValid = 1'b1;
      wIn     = 20'h04000;
      dIn     = 20'h02000;
      @(posedge clk); #1;
      inValid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      checkOutput("midReset.inReady", 32'(inReady), 32'd0);
      checkOutput("midReset.busy", 32'(busy), 32'd0);
      checkOutput("midReset.outValid", 32'(outValid), 32'd0);
      checkOutput("midReset.deltaOut", 32'(deltaOut), 32'd0);
      #2;
      rst = 1'b0;
      applyStimulus("afterReset", 20'h02000, 20'h04000, 20'h02000, 20'h02000, 20'h04000, 1'b0, res);
      checkOutput("afterReset.delta", 32'(res), 32'h01000);
      releaseOutput("afterReset", 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
